// File: rtl/tx_axis_arbiter.sv
// Frame-granular round-robin arbiter in front of the 10G TX MAC: one source per frame,
// oversized frames are cut at MAX_FRAME_WORDS beats and the remainder drained.
module tx_axis_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH/8,
    parameter int MAX_FRAME_WORDS = 380,
    parameter int GRANT_WIDTH     = $clog2(NUM_PORTS)
) (
    input  logic                                 tx_clk,
    input  logic                                 tx_rst,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] in_slave_tx_tdata,
    input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] in_slave_tx_tkeep,
    input  logic [NUM_PORTS-1:0]                 in_slave_tx_tvalid,
    input  logic [NUM_PORTS-1:0]                 in_slave_tx_tlast,
    output logic [NUM_PORTS-1:0]                 out_slave_tx_tready,
    output logic [AXIS_DATA_WIDTH-1:0]           out_master_tx_tdata,
    output logic [AXIS_DATA_BYTES-1:0]           out_master_tx_tkeep,
    output logic                                 out_master_tx_tvalid,
    output logic                                 out_master_tx_tlast,
    input  logic                                 in_master_tx_tready,
    output logic [GRANT_WIDTH-1:0]               out_grant,
    output logic                                 out_busy,
    output logic                                 out_frame_trunc
);
    localparam int CNT_W = ($clog2(MAX_FRAME_WORDS+1) > 9) ? $clog2(MAX_FRAME_WORDS+1) : 9;
    localparam logic [CNT_W-1:0]       MAX_CNT   = CNT_W'(MAX_FRAME_WORDS);
    localparam logic [CNT_W-1:0]       LAST_CNT  = CNT_W'(MAX_FRAME_WORDS-1);
    localparam logic [GRANT_WIDTH-1:0] LAST_PORT = GRANT_WIDTH'(NUM_PORTS-1);
    localparam logic [GRANT_WIDTH:0]   NP_W      = (GRANT_WIDTH+1)'(NUM_PORTS);

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_DRAIN} state_t;

    state_t                     r_state, w_state_nxt;
    logic [GRANT_WIDTH-1:0]     r_rr_ptr, r_grant, w_pick, w_grant_inc;
    logic [GRANT_WIDTH:0]       w_idx;
    logic                       w_pick_vld;
    logic [CNT_W-1:0]           r_word_cnt;
    logic                       r_tvalid, r_tlast, r_trunc;
    logic [AXIS_DATA_WIDTH-1:0] r_tdata;
    logic [AXIS_DATA_BYTES-1:0] r_tkeep;
    logic                       w_out_free, w_sel_vld, w_sel_last, w_rdy_sel;
    logic                       w_accept, w_load, w_trunc_now, w_advance;

    logic [AXIS_DATA_WIDTH-1:0] w_port_data [NUM_PORTS];
    logic [AXIS_DATA_BYTES-1:0] w_port_keep [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign w_port_data[p] = in_slave_tx_tdata[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        assign w_port_keep[p] = in_slave_tx_tkeep[p*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
    end

    // Scan from the far end back toward rr_ptr so the closest requester wins.
    always_comb begin
        w_pick     = r_rr_ptr;
        w_pick_vld = 1'b0;
        w_idx      = '0;
        for (int i = NUM_PORTS-1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr_ptr} + (GRANT_WIDTH+1)'(i);
            if (w_idx >= NP_W) w_idx = w_idx - NP_W;
            if (in_slave_tx_tvalid[w_idx[GRANT_WIDTH-1:0]]) begin
                w_pick     = w_idx[GRANT_WIDTH-1:0];
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_grant_inc = (r_grant == LAST_PORT) ? '0 : r_grant + 1'b1;
    assign w_out_free  = !r_tvalid || in_master_tx_tready;
    assign w_sel_vld   = in_slave_tx_tvalid[r_grant];
    assign w_sel_last  = in_slave_tx_tlast[r_grant];
    assign w_accept    = w_rdy_sel && w_sel_vld;

    always_comb begin
        w_state_nxt = r_state;
        w_rdy_sel   = 1'b0;
        w_load      = 1'b0;
        w_trunc_now = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: if (w_pick_vld) w_state_nxt = S_PASS;
            S_PASS: begin
                w_rdy_sel = w_out_free;
                if (w_out_free && w_sel_vld) begin
                    w_load = 1'b1;
                    if (w_sel_last) begin
                        w_state_nxt = S_IDLE;
                        w_advance   = 1'b1;
                    end else if (r_word_cnt == LAST_CNT) begin
                        w_trunc_now = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_rdy_sel = 1'b1;
                if (w_sel_vld && w_sel_last) begin
                    w_state_nxt = S_IDLE;
                    w_advance   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_word_cnt <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_trunc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_pick_vld) begin
                r_grant    <= w_pick;
                r_word_cnt <= '0;
            end else if (w_accept && r_word_cnt != MAX_CNT) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_advance) r_rr_ptr <= w_grant_inc;
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_port_data[r_grant];
                r_tkeep  <= w_port_keep[r_grant];
                r_tlast  <= w_sel_last || w_trunc_now;
            end else if (in_master_tx_tready) begin
                r_tvalid <= 1'b0;
            end
            r_trunc <= w_trunc_now;
        end
    end

    assign out_slave_tx_tready  = w_rdy_sel ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << r_grant) : '0;
    assign out_master_tx_tdata  = r_tdata;
    assign out_master_tx_tkeep  = r_tkeep;
    assign out_master_tx_tvalid = r_tvalid;
    assign out_master_tx_tlast  = r_tlast;
    assign out_grant            = r_grant;
    assign out_busy             = (r_state != S_IDLE);
    assign out_frame_trunc      = r_trunc;

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Randomized bench for tx_axis_arbiter: frame queues per port, expected output stream
// built from round-robin-by-frame order with truncation at MAXW beats.
module tb_tx_axis_arbiter;
    localparam int NP = 4, DW = 32, KB = 4, MAXW = 380, GW = 2;

    logic             tx_clk = 1'b0;
    logic             tx_rst = 1'b1;
    logic [NP*DW-1:0] s_tdata;
    logic [NP*KB-1:0] s_tkeep;
    logic [NP-1:0]    s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]    m_tdata;
    logic [KB-1:0]    m_tkeep;
    logic             m_tvalid, m_tlast, m_tready;
    logic [GW-1:0]    grant;
    logic             busy, trunc;

    tx_axis_arbiter #(.NUM_PORTS(NP), .AXIS_DATA_WIDTH(DW), .MAX_FRAME_WORDS(MAXW)) dut (
        .tx_clk(tx_clk), .tx_rst(tx_rst),
        .in_slave_tx_tdata(s_tdata), .in_slave_tx_tkeep(s_tkeep),
        .in_slave_tx_tvalid(s_tvalid), .in_slave_tx_tlast(s_tlast),
        .out_slave_tx_tready(s_tready),
        .out_master_tx_tdata(m_tdata), .out_master_tx_tkeep(m_tkeep),
        .out_master_tx_tvalid(m_tvalid), .out_master_tx_tlast(m_tlast),
        .in_master_tx_tready(m_tready),
        .out_grant(grant), .out_busy(busy), .out_frame_trunc(trunc)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct packed { logic [DW-1:0] d; logic [KB-1:0] k; logic l; } beat_t;
    typedef struct packed { beat_t b; logic [GW-1:0] p; } exp_t;

    beat_t src_q [NP][$];
    int    src_idx [NP];
    exp_t  exp_q [$];
    int    mrr;
    int    exp_trunc;
    int    total, bad;
    int    fo, ic;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic add_frame(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = $urandom;
            b.k = 4'($urandom_range(15));
            b.l = (i == len-1);
            src_q[p].push_back(b);
        end
    endtask

    task automatic clear_src();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            src_idx[p] = 0;
        end
        s_tvalid = '0;
    endtask

    function automatic bit all_done();
        for (int p = 0; p < NP; p++)
            if (src_idx[p] < src_q[p].size()) return 1'b0;
        return 1'b1;
    endfunction

    // Frame order: first port with frames left, scanning from mrr; each frame cut at MAXW.
    task automatic build_model();
        int   pos [NP];
        int   p, n;
        bit   found;
        exp_t e;
        exp_trunc = 0;
        for (int i = 0; i < NP; i++) pos[i] = 0;
        while (1) begin
            found = 1'b0;
            p = 0;
            for (int i = 0; i < NP && !found; i++) begin
                p = (mrr + i) % NP;
                if (pos[p] < src_q[p].size()) found = 1'b1;
            end
            if (!found) break;
            n = 0;
            while (1) begin
                e.b = src_q[p][pos[p]];
                pos[p]++;
                n++;
                if (n <= MAXW) begin
                    if (n == MAXW && !e.b.l) exp_trunc++;
                    e.b.l = e.b.l || (n == MAXW);
                    e.p   = GW'(p);
                    exp_q.push_back(e);
                end
                if (src_q[p][pos[p]-1].l) break;
            end
            mrr = (p + 1) % NP;
        end
    endtask

    task automatic drive(input logic [NP-1:0] hs, input int rdy, input int gap);
        beat_t b;
        bit    first;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) src_idx[p]++;
            if (src_idx[p] < src_q[p].size()) begin
                first = (src_idx[p] == 0) || src_q[p][src_idx[p]-1].l;
                if (!(s_tvalid[p] && !hs[p]))
                    s_tvalid[p] = first || ($urandom_range(99) >= gap);
                b = src_q[p][src_idx[p]];
                s_tdata[p*DW +: DW] = b.d;
                s_tkeep[p*KB +: KB] = b.k;
                s_tlast[p]          = b.l;
            end else begin
                s_tvalid[p] = 1'b0;
            end
        end
        m_tready = ($urandom_range(99) < rdy);
    endtask

    task automatic run(input int rdy, input int gap, input int stop_hs, input bit chk_grant,
                       output int first_out, output int idle_cnt);
        logic [NP-1:0] hs;
        int    iter, nhs, ntrunc;
        bit    seen_busy, prev_stall;
        beat_t held;
        exp_t  e;
        iter = 0; nhs = 0; ntrunc = 0; seen_busy = 0; prev_stall = 0; held = '0;
        first_out = -1; idle_cnt = 0;
        build_model();
        @(posedge tx_clk); #1;
        drive('0, rdy, gap);
        forever begin
            @(negedge tx_clk);
            chk("tready_onehot", 64'($countones(s_tready) <= 1), 1);
            chk("tready_granted", 64'(s_tready & ~(4'b0001 << grant)), 0);
            if (prev_stall) begin
                chk("hold_valid", 64'(m_tvalid), 1);
                chk("hold_beat", 64'({m_tdata, m_tkeep, m_tlast}), 64'(held));
            end
            if (trunc) ntrunc++;
            if (busy) seen_busy = 1'b1;
            else if (seen_busy && !all_done()) idle_cnt++;
            if (m_tvalid && m_tready) begin
                if (first_out < 0) first_out = iter;
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({m_tdata, m_tkeep, m_tlast}), 64'(e.b));
                    if (chk_grant) chk("grant", 64'(grant), 64'(e.p));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            held = {m_tdata, m_tkeep, m_tlast};
            hs = s_tvalid & s_tready;
            nhs += $countones(hs);
            if (stop_hs > 0 && nhs >= stop_hs) return;
            if (all_done() && exp_q.size() == 0) break;
            iter++;
            if (iter > 20000) begin
                chk("timeout", 0, 1);
                break;
            end
            @(posedge tx_clk); #1;
            drive(hs, rdy, gap);
        end
        chk("trunc_cnt", 64'(ntrunc), 64'(exp_trunc));
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_tvalid"}, 64'(m_tvalid), 0);
        chk({pfx, "_tlast"},  64'(m_tlast), 0);
        chk({pfx, "_tdata"},  64'(m_tdata), 0);
        chk({pfx, "_tkeep"},  64'(m_tkeep), 0);
        chk({pfx, "_busy"},   64'(busy), 0);
        chk({pfx, "_trunc"},  64'(trunc), 0);
        chk({pfx, "_tready"}, 64'(s_tready), 0);
        chk({pfx, "_grant"},  64'(grant), 0);
    endtask

    initial begin
        total = 0; bad = 0; mrr = 0;
        s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
        tx_rst = 1'b1;
        repeat (3) @(posedge tx_clk);
        #1 tx_rst = 1'b0;
        @(negedge tx_clk);
        chk_zero("reset");

        clear_src();
        add_frame(0, 16);
        run(100, 0, 0, 1'b1, fo, ic);
        chk("first_out_latency", 64'(fo), 2);

        clear_src();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 3; p++) add_frame(p, 4);
        run(100, 0, 0, 1'b1, fo, ic);
        chk("idle_between_frames", 64'(ic), 5);

        clear_src();
        add_frame(1, 4);
        add_frame(3, 4);
        run(100, 0, 0, 1'b1, fo, ic);

        clear_src();
        add_frame(3, 2);
        add_frame(0, 2);
        run(100, 0, 0, 1'b1, fo, ic);

        clear_src();
        add_frame(2, 400);
        add_frame(0, 3);
        add_frame(1, 380);
        add_frame(3, 381);
        run(100, 0, 0, 1'b1, fo, ic);

        clear_src();
        for (int f = 0; f < 40; f++) add_frame($urandom_range(NP-1), ($urandom_range(1)) ? 3 : 1);
        run(50, 25, 0, 1'b0, fo, ic);

        clear_src();
        for (int f = 0; f < 30; f++) add_frame($urandom_range(NP-1), 1 + $urandom_range(4));
        run(30, 40, 0, 1'b0, fo, ic);

        clear_src();
        add_frame(1, 2);
        run(100, 0, 0, 1'b1, fo, ic);

        clear_src();
        add_frame(2, 10);
        run(100, 0, 5, 1'b0, fo, ic);
        tx_rst = 1'b1;
        @(posedge tx_clk); #1;
        tx_rst = 1'b0;
        clear_src();
        exp_q.delete();
        mrr = 0;
        @(negedge tx_clk);
        chk_zero("midrst");

        clear_src();
        add_frame(2, 3);
        add_frame(1, 3);
        add_frame(0, 3);
        run(100, 0, 0, 1'b1, fo, ic);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
